// File: rtl/odd_parity_checker_pkg.sv
// Shared constants for the odd-parity receive checker.
package odd_parity_checker_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/odd_parity_checker_parity5_xor.sv
// Pure combinational XOR-reduce of a 4-bit nibble plus its parity bit.
module parity5_xor (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic p,
  output logic odd
);

  assign odd = ^{a, b, c, d, p};

endmodule

// File: rtl/odd_parity_checker.sv
// Odd-parity checker: combinational error flag plus registered error, saturating
// error counter and sticky error flag, all updated only on qualified words.
module odd_parity_checker
  import odd_parity_checker_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  input  logic             chk_en,
  output logic             pec,
  output logic             pec_q,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  logic             odd;
  logic             pec_q_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_sticky_d;
  logic             err_sticky_q;

  parity5_xor u_parity5_xor (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .p   (p),
    .odd (odd)
  );

  // An even ones count across the five bits is a parity error.
  assign pec = ~odd;

  always_comb begin
    pec_q_d      = pec_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (chk_en) begin
      pec_q_d = pec;
      if (pec) begin
        err_sticky_d = 1'b1;
        if (err_cnt_q != {CNT_W{1'b1}}) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pec_q        <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      pec_q        <= pec_q_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_odd_parity_checker.sv
// Scoreboard bench for odd_parity_checker: default-width and 2-bit-counter
// instances share stimulus; a monitor pops expected registered state each cycle.
module tb_odd_parity_checker;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, p = 1'b0;
  logic chk_en = 1'b0;

  logic       pec8, pecq8, st8;
  logic [7:0] cnt8;
  logic       pec2, pecq2, st2;
  logic [1:0] cnt2;

  typedef struct {
    logic       pecq;
    int         cnt8;
    logic [1:0] cnt2;
    logic       sticky;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_cnt8 = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  odd_parity_checker #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .p(p), .chk_en(chk_en),
    .pec(pec8), .pec_q(pecq8), .err_cnt(cnt8), .err_sticky(st8)
  );

  odd_parity_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .p(p), .chk_en(chk_en),
    .pec(pec2), .pec_q(pecq2), .err_cnt(cnt2), .err_sticky(st2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one word at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic [4:0] w, input logic en, input logic r,
                      input logic e_pecq, input logic [1:0] e_cnt2, input logic e_sticky);
    exp_t e;
    @(negedge clk);
    {a, b, c, d, p} = w;
    chk_en = en;
    rst = r;
    if (r) model_cnt8 = 0;
    else if (en && e_pecq && model_cnt8 < 255) model_cnt8++;
    e.pecq = e_pecq;
    e.cnt8 = model_cnt8;
    e.cnt2 = e_cnt2;
    e.sticky = e_sticky;
    sb.push_back(e);
    $display("issue w=%b en=%0d rst=%0d exp pec_q=%0d cnt2=%0d cnt8=%0d sticky=%0d",
             w, en, r, e_pecq, e_cnt2, model_cnt8, e_sticky);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pec_q_w8", int'(pecq8), int'(e.pecq));
      check("pec_q_w2", int'(pecq2), int'(e.pecq));
      check("err_cnt_w8", int'(cnt8), e.cnt8);
      check("err_cnt_w2", int'(cnt2), int'(e.cnt2));
      check("err_sticky_w8", int'(st8), int'(e.sticky));
      check("err_sticky_w2", int'(st2), int'(e.sticky));
      $display("txn pec_q=%0d/%0d cnt=%0d/%0d sticky=%0d/%0d",
               pecq8, pecq2, cnt8, cnt2, st8, st2);
    end
  end

  initial begin
    logic [4:0] code;
    logic exp_pec;

    // Combinational sweep with the clock stopped; p is the fastest-toggling bit.
    for (int i = 0; i < 32; i++) begin
      code = 5'(i);
      {a, b, c, d, p} = code;
      #12;
      exp_pec = ($countones(code) % 2) == 0;
      check($sformatf("pec_sweep_%b_w8", code), int'(pec8), int'(exp_pec));
      check($sformatf("pec_sweep_%b_w2", code), int'(pec2), int'(exp_pec));
      $display("sweep abcdp=%b pec=%0d", code, pec8);
      #13;
    end

    clk_run = 1'b1;

    // Reset dominates an enabled error word.
    step(5'b00000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(5'b00000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

    // Qualified error (two ones), then a good word (one one).
    step(5'b10001, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    step(5'b10000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);

    // Gating: error inputs without chk_en leave registered state alone.
    for (int i = 0; i < 5; i++) begin
      step(5'b00000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
      #1;
      check("pec_gated_w8", int'(pec8), 1);
      check("pec_gated_w2", int'(pec2), 1);
    end

    // Saturation of the 2-bit counter.
    step(5'b00000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(5'b00000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    step(5'b11000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    step(5'b00011, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    step(5'b11110, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    step(5'b10100, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);

    // Mid-run reset on an enabled error word, then counting resumes at 1.
    step(5'b00000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(5'b01100, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    step(5'b01010, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    step(5'b00110, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(5'b11011, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    step(5'b11100, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);

    @(negedge clk);
    chk_en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
